// File: rtl/sha_mem_responder.sv
// Word-addressed 32-bit memory shared by the SHA-256 engine and a host, with a digest-writeback monitor.
// Optional macro SHA_MEM_PROTECT_EN drops engine writes into the message window.
module sha_mem_responder #(
    parameter int          DEPTH    = 256,
    parameter logic [15:0] OUT_BASE = 16'h0080,
    parameter logic [15:0] MSG_BASE = 16'h0000,
    parameter int          MSG_LEN  = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        sha_done,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    output logic        digest_valid,
    output logic [7:0]  digest_count,
    output logic        addr_err,
    output logic        digest_err
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CMPL = 2'd2;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] mem_read_data_q, host_rdata_q;
    logic        host_rvalid_q, addr_err_q, done_q;
    logic [1:0]  state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic        dvalid_q, dvalid_d;
    logic [7:0]  count_q, count_d;
    logic        derr_q, derr_d;

    logic          eng_in, host_in, eng_wr, host_wr, host_rd, err_set;
    logic          msg_hit, prot_drop, out_hit, rise, fall;
    logic [16:0]   out_off, msg_off;
    logic [7:0]    hit_vec;
    logic [AW-1:0] eng_idx, host_idx;

    assign eng_in   = {1'b0, mem_addr}  < DEPTH_W;
    assign host_in  = {1'b0, host_addr} < DEPTH_W;
    assign eng_idx  = mem_addr[AW-1:0];
    assign host_idx = host_addr[AW-1:0];

    // Offsets wrap to a large value below the base, so one unsigned compare bounds each window.
    assign out_off = {1'b0, mem_addr} - {1'b0, OUT_BASE};
    assign msg_off = {1'b0, mem_addr} - {1'b0, MSG_BASE};
    assign out_hit = out_off < 17'd8;
    assign msg_hit = msg_off < 17'(MSG_LEN);

`ifdef SHA_MEM_PROTECT_EN
    assign prot_drop = msg_hit;
`else
    logic unused_msg_hit;
    assign unused_msg_hit = msg_hit;
    assign prot_drop      = 1'b0;
`endif

    assign host_gnt = host_req & sha_done;
    assign host_rd  = host_gnt & ~host_we;
    assign host_wr  = host_gnt & host_we & host_in;
    assign eng_wr   = mem_we & ~sha_done & eng_in & ~prot_drop;
    assign err_set  = (~mem_we & ~eng_in)
                    | (mem_we & ~sha_done & (~eng_in | prot_drop))
                    | (host_gnt & ~host_in);

    // Ownership makes engine and host writes mutually exclusive; the array has no reset.
    always_ff @(posedge clk) begin
        if (eng_wr)
            mem_q[eng_idx] <= mem_write_data;
        else if (host_wr)
            mem_q[host_idx] <= host_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_data_q <= '0;
            host_rdata_q    <= '0;
            host_rvalid_q   <= 1'b0;
            addr_err_q      <= 1'b0;
            done_q          <= 1'b1;
            state_q         <= ST_IDLE;
            mask_q          <= '0;
            dvalid_q        <= 1'b0;
            count_q         <= '0;
            derr_q          <= 1'b0;
        end else begin
            if (!mem_we)
                mem_read_data_q <= eng_in ? mem_q[eng_idx] : '0;
            if (host_rd)
                host_rdata_q <= host_in ? mem_q[host_idx] : '0;
            host_rvalid_q <= host_rd;
            addr_err_q    <= addr_err_q | err_set;
            done_q        <= sha_done;
            state_q       <= state_d;
            mask_q        <= mask_d;
            dvalid_q      <= dvalid_d;
            count_q       <= count_d;
            derr_q        <= derr_d;
        end
    end

    assign rise    = ~done_q & sha_done;
    assign fall    = done_q & ~sha_done;
    // Not gated by sha_done: a final digest write landing with the done rise still completes the run.
    assign hit_vec = (mem_we && out_hit) ? (8'b1 << out_off[2:0]) : 8'b0;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        dvalid_d = dvalid_q;
        count_d  = count_q;
        derr_d   = derr_q;
        case (state_q)
            ST_IDLE: if (fall) begin
                mask_d   = '0;
                dvalid_d = 1'b0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                mask_d = mask_q | hit_vec;
                if (&mask_d) begin
                    state_d  = ST_CMPL;
                    dvalid_d = 1'b1;
                    count_d  = count_q + 8'd1;
                end else if (rise) begin
                    derr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CMPL: if (fall) begin
                mask_d   = '0;
                dvalid_d = 1'b0;
                state_d  = ST_RUN;
            end else if (sha_done) begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_read_data = mem_read_data_q;
    assign host_rdata    = host_rdata_q;
    assign host_rvalid   = host_rvalid_q;
    assign digest_valid  = dvalid_q;
    assign digest_count  = count_q;
    assign addr_err      = addr_err_q;
    assign digest_err    = derr_q;
endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: directed vector table, corner sequences, random traffic vs a reference model.
module tb_sha_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_we, sha_done, host_req, host_we;
    logic [15:0] mem_addr, host_addr;
    logic [31:0] mem_write_data, host_wdata;
    logic [31:0] mem_read_data, host_rdata;
    logic        host_gnt, host_rvalid, digest_valid, addr_err, digest_err;
    logic [7:0]  digest_count;

    sha_mem_responder dut (
        .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .sha_done(sha_done), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .digest_valid(digest_valid), .digest_count(digest_count),
        .addr_err(addr_err), .digest_err(digest_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_mem [256];
    logic [31:0] m_mrd, m_hrd;
    logic        m_rv, m_dv, m_aerr, m_derr, m_prev;
    logic [7:0]  m_cnt;
    int          m_phase;          // 0 waiting for start, 1 collecting digest, 2 digest complete
    bit          m_seen [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit rise, fall, gnt, ein, hin, prot, all;
        int k;
        rise = sha_done && !m_prev;
        fall = !sha_done && m_prev;
        gnt  = host_req && sha_done;
        ein  = mem_addr < 16'd256;
        hin  = host_addr < 16'd256;
        prot = 1'b0;
`ifdef SHA_MEM_PROTECT_EN
        prot = mem_addr < 16'd20;
`endif
        if (reset) begin
            m_mrd = 0; m_hrd = 0; m_rv = 0; m_dv = 0; m_cnt = 0;
            m_aerr = 0; m_derr = 0; m_phase = 0; m_prev = 1;
        end else begin
            if (!mem_we) m_mrd = ein ? m_mem[mem_addr[7:0]] : 32'h0;
            m_rv = gnt && !host_we;
            if (gnt && !host_we) m_hrd = hin ? m_mem[host_addr[7:0]] : 32'h0;
            if ((!mem_we && !ein) || (mem_we && !sha_done && (!ein || prot)) || (gnt && !hin))
                m_aerr = 1;
            case (m_phase)
                0: if (fall) begin
                    foreach (m_seen[i]) m_seen[i] = 0;
                    m_dv = 0; m_phase = 1;
                end
                1: begin
                    if (mem_we && mem_addr >= 16'h80 && mem_addr <= 16'h87) begin
                        k = int'(mem_addr) - 'h80;
                        m_seen[k] = 1;
                    end
                    all = 1;
                    foreach (m_seen[i]) if (!m_seen[i]) all = 0;
                    if (all) begin
                        m_phase = 2; m_dv = 1; m_cnt = m_cnt + 8'd1;
                    end else if (rise) begin
                        m_derr = 1; m_phase = 0;
                    end
                end
                default: if (fall) begin
                    foreach (m_seen[i]) m_seen[i] = 0;
                    m_dv = 0; m_phase = 1;
                end else if (sha_done) begin
                    m_phase = 0;
                end
            endcase
            m_prev = sha_done;
        end
        if (mem_we && !sha_done && ein && !prot) m_mem[mem_addr[7:0]] = mem_write_data;
        else if (gnt && host_we && hin) m_mem[host_addr[7:0]] = host_wdata;
    endtask

    task automatic step();
        #1;
        chk("host_gnt", {31'b0, host_gnt}, {31'b0, host_req && sha_done});
        model_edge();
        @(posedge clk); #1;
        chk("mem_read_data", mem_read_data, m_mrd);
        chk("host_rdata", host_rdata, m_hrd);
        chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, m_rv});
        chk("digest_valid", {31'b0, digest_valid}, {31'b0, m_dv});
        chk("digest_count", {24'b0, digest_count}, {24'b0, m_cnt});
        chk("addr_err", {31'b0, addr_err}, {31'b0, m_aerr});
        chk("digest_err", {31'b0, digest_err}, {31'b0, m_derr});
    endtask

    task automatic drive(input logic d, input logic we, input logic [15:0] ma, input logic [31:0] md,
                         input logic hr, input logic hw, input logic [15:0] ha, input logic [31:0] hd);
        reset = 1'b0; sha_done = d; mem_we = we; mem_addr = ma; mem_write_data = md;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    localparam int S_MRD = 1, S_HRD = 2, S_RV = 3, S_DV = 4, S_CNT = 5, S_AERR = 6, S_DERR = 7;

    typedef struct {
        logic        done, we;
        logic [15:0] ma;
        logic [31:0] md;
        logic        hr;
        logic [15:0] ha;
        int          sig;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(logic d, logic we, logic [15:0] ma, logic [31:0] md,
                                logic hr, logic [15:0] ha, int sig, logic [31:0] exp);
        vec_t v;
        v.done = d; v.we = we; v.ma = ma; v.md = md; v.hr = hr; v.ha = ha; v.sig = sig; v.exp = exp;
        return v;
    endfunction

    function automatic logic [31:0] actual(int s);
        case (s)
            S_MRD:  return mem_read_data;
            S_HRD:  return host_rdata;
            S_RV:   return {31'b0, host_rvalid};
            S_DV:   return {31'b0, digest_valid};
            S_CNT:  return {24'b0, digest_count};
            S_AERR: return {31'b0, addr_err};
            default: return {31'b0, digest_err};
        endcase
    endfunction

    initial begin
        vec_t tbl[$];
        int r;

        // Reset with the engine write strobe held so no uninitialised word is read.
        drive(1, 1, 16'h80, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(); step();
        chk("rst_mem_read_data", mem_read_data, 32'h0);
        chk("rst_digest_count", {24'b0, digest_count}, 32'h0);

        for (int i = 0; i < 256; i++) begin
            drive(1, 1, 16'h80, 0, 1, 1, 16'(i), 32'(i));
            step();
        end

        tbl.push_back(mk(1, 1, 16'h80, 0, 1, 16'h7, S_HRD, 32'h7));
        tbl.push_back(mk(1, 1, 16'h80, 0, 0, 16'h0, S_RV, 32'h0));
        tbl.push_back(mk(0, 0, 16'h5, 0, 1, 16'h9, S_MRD, 32'h5));
        tbl.push_back(mk(0, 0, 16'h5, 0, 1, 16'h9, S_RV, 32'h0));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(0, 1, 16'(16'h80 + k), 32'(32'hA0 + k), 0, 0, S_DV, 32'h0));
        tbl.push_back(mk(0, 1, 16'h87, 32'hA7, 0, 0, S_DV, 32'h1));
        tbl.push_back(mk(1, 0, 16'h10, 0, 0, 0, S_CNT, 32'h1));
        tbl.push_back(mk(1, 0, 16'h10, 0, 1, 16'h83, S_HRD, 32'hA3));
        tbl.push_back(mk(0, 0, 16'h10, 0, 0, 0, S_DV, 32'h0));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0, 1, 16'(16'h80 + k), 32'(32'hB0 + k), 0, 0, S_DV, 32'h0));
        tbl.push_back(mk(1, 0, 16'h10, 0, 0, 0, S_DERR, 32'h1));
        tbl.push_back(mk(1, 0, 16'h10, 0, 0, 0, S_DV, 32'h0));
        tbl.push_back(mk(1, 0, 16'h100, 0, 0, 0, S_MRD, 32'h0));
        tbl.push_back(mk(1, 0, 16'h7, 0, 0, 0, S_AERR, 32'h1));
        tbl.push_back(mk(1, 0, 16'h7, 0, 0, 0, S_MRD, 32'h7));

        foreach (tbl[i]) begin
            drive(tbl[i].done, tbl[i].we, tbl[i].ma, tbl[i].md, tbl[i].hr, 1'b0, tbl[i].ha, 0);
            step();
            chk($sformatf("vec%0d", i), actual(tbl[i].sig), tbl[i].exp);
        end

        // Reset mid-operation: flags clear, memory survives.
        drive(1, 0, 16'h7, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(); step();
        chk("rst_addr_err", {31'b0, addr_err}, 32'h0);
        chk("rst_digest_err", {31'b0, digest_err}, 32'h0);
        drive(1, 0, 16'h7, 0, 1, 0, 16'h7, 0);
        step();
        chk("persist_word7", host_rdata, 32'h7);

        // Final digest write coincides with the done rise: completion, no error.
        drive(0, 0, 16'h7, 0, 0, 0, 0, 0); step();
        for (int k = 0; k < 7; k++) begin
            drive(0, 1, 16'(16'h80 + k), 32'(32'hC0 + k), 0, 0, 0, 0); step();
        end
        drive(1, 1, 16'h87, 32'hC7, 0, 0, 0, 0); step();
        chk("same_cycle_valid", {31'b0, digest_valid}, 32'h1);
        chk("same_cycle_err", {31'b0, digest_err}, 32'h0);
        chk("same_cycle_count", {24'b0, digest_count}, 32'h1);
        drive(0, 0, 16'h7, 0, 0, 0, 0, 0); step();
        chk("restart_clears_valid", {31'b0, digest_valid}, 32'h0);
        drive(1, 0, 16'h7, 0, 0, 0, 0, 0); step();
        chk("empty_run_err", {31'b0, digest_err}, 32'h1);

        // Engine write into the message window.
        drive(1, 0, 16'h7, 0, 0, 0, 0, 0);
        reset = 1'b1; step();
        drive(0, 0, 16'h7, 0, 0, 0, 0, 0); step();
        drive(0, 1, 16'h3, 32'hFFFF_FFFF, 0, 0, 0, 0); step();
        drive(1, 0, 16'h7, 0, 1, 0, 16'h3, 0); step();
`ifdef SHA_MEM_PROTECT_EN
        chk("prot_word3", host_rdata, 32'h3);
        chk("prot_addr_err", {31'b0, addr_err}, 32'h1);
`else
        chk("noprot_word3", host_rdata, 32'hFFFF_FFFF);
        chk("noprot_addr_err", {31'b0, addr_err}, 32'h0);
`endif

        // Random traffic against the model.
        sha_done = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                drive(1, 0, 16'h7, 0, 0, 0, 0, 0);
                reset = 1'b1;
            end else begin
                logic d;
                d = sha_done;
                if (d && $urandom_range(0, 5) == 0) d = 1'b0;
                else if (!d && $urandom_range(0, 39) == 0) d = 1'b1;
                drive(d, 1'($urandom_range(0, 1)), 16'h0, $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'h0, $urandom);
                r = $urandom_range(0, 9);
                mem_addr  = (r < 6) ? 16'(16'h80 + $urandom_range(0, 7))
                          : (r < 9) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                r = $urandom_range(0, 9);
                host_addr = (r < 9) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
